render_rect: RTL and testbench
==============================

RENDER_RECT -- requirements
Module: render_rect

Interface
REQ-001 The module SHALL have parameter NX, default 10, meaning X coordinate width in bits.
REQ-002 The module SHALL have parameter NY, default 9, meaning Y coordinate width in bits.
REQ-003 The module SHALL have parameter CW, default 9, meaning colour width in bits (RRR_GGG_BBB at default).
REQ-004 The module SHALL have parameter XMAX, default 640, meaning the first off-screen X value.
REQ-005 The module SHALL have parameter YMAX, default 480, meaning the first off-screen Y value.
REQ-006 CLOCK_50  input  1  system clock, all state on rising edge.
REQ-007 resetn  input  1  synchronous active-low reset.
REQ-008 start  input  1  request to draw one rectangle; sampled only in IDLE.
REQ-009 x0  input  NX  top-left X; y0  input  NY  top-left Y.
REQ-010 w  input  NX  rectangle width in pixels; h  input  NY  rectangle height in pixels.
REQ-011 color  input  CW  fill/outline colour.
REQ-012 mode  input  1  0 = solid fill, 1 = 1-pixel outline only.
REQ-013 pready  input  1  pixel sink accepts the presented write this cycle.
REQ-014 px  output  NX, py  output  NY, pcolor  output  CW  presented pixel address and colour.
REQ-015 pwrite  output  1  presented pixel is valid and must be written.
REQ-016 busy  output  1  high from the cycle after an accepted start until return to IDLE.
REQ-017 done  output  1  one-cycle pulse on completion.

Function
REQ-018 The FSM SHALL have states IDLE, DRAW, DONE.
REQ-019 In IDLE with start=1, the block SHALL latch x0, y0, w, h, color, mode, clear the column counter xc and row counter yc, and go to DRAW; if w==0 or h==0 it SHALL go to DONE directly with no pwrite.
REQ-020 start SHALL be ignored in DRAW and DONE; latched inputs SHALL not change until the next IDLE acceptance.
REQ-021 In DRAW, px SHALL equal x0+xc truncated to NX bits, py SHALL equal y0+yc truncated to NY bits, and pcolor SHALL equal the latched colour.
REQ-022 A pixel SHALL be visible if the (NX+1)-bit sum x0+xc < XMAX, the (NY+1)-bit sum y0+yc < YMAX, and, in outline mode, xc==0 or xc==w-1 or yc==0 or yc==h-1.
REQ-023 pwrite SHALL be 1 in DRAW exactly when the current pixel is visible; outside DRAW, pwrite SHALL be 0.
REQ-024 The scan SHALL advance when pwrite=0 or pready=1; with pwrite=1 and pready=0 the block SHALL hold px, py, pcolor and pwrite stable.
REQ-025 The advance order SHALL be raster: xc increments until w-1, then xc clears and yc increments.
REQ-026 Advancing from xc==w-1, yc==h-1 SHALL enter DONE; DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-027 The first pixel SHALL be presented the cycle after start is accepted; with pready held 1, DRAW SHALL last exactly w*h cycles.
REQ-028 Off-screen pixels SHALL be skipped at one cycle each with no pwrite.
REQ-029 busy SHALL be 1 in DRAW and DONE and 0 in IDLE; start in the same cycle as done SHALL be ignored.

Reset
REQ-030 When resetn=0 at a rising edge, the block SHALL enter IDLE and clear xc and yc, with busy=0, done=0 and pwrite=0 from the next cycle, including mid-DRAW with no further writes.
REQ-031 The reset values of px, py and pcolor SHALL be 0.

Verification
REQ-032 Fill: x0=10, y0=5, w=3, h=2, mode=0, pready=1 -> 6 writes (10,5)(11,5)(12,5)(10,6)(11,6)(12,6), done 7 cycles after start.
REQ-033 Outline: x0=0, y0=0, w=4, h=3, mode=1 -> 10 writes, with (1,1) and (2,1) absent; DRAW lasts 12 cycles.
REQ-034 Clip: x0=638, y0=478, w=4, h=4, fill -> only (638,478)(639,478)(638,479)(639,479) written; DRAW lasts 16 cycles.
REQ-035 Stall: pready=0 for 3 cycles on the second pixel -> px/py/pwrite stable for those cycles and no pixel duplicated or lost.
REQ-036 Degenerate and reset: w=0 -> done 1 cycle after start with no pwrite; resetn=0 mid-DRAW -> no pwrite thereafter and busy=0.

Source files
------------

// File: rtl/render_rect_if.sv
// render_rect_if: rectangle draw request in, pixel write stream out.
interface render_rect_if #(parameter int NX = 10, parameter int NY = 9, parameter int CW = 9);
    logic          start;
    logic [NX-1:0] x0;
    logic [NY-1:0] y0;
    logic [NX-1:0] w;
    logic [NY-1:0] h;
    logic [CW-1:0] color;
    logic          mode;
    logic          pready;
    logic [NX-1:0] px;
    logic [NY-1:0] py;
    logic [CW-1:0] pcolor;
    logic          pwrite;
    logic          busy;
    logic          done;
    modport master (output start, x0, y0, w, h, color, mode, pready,
                    input px, py, pcolor, pwrite, busy, done);
    modport slave  (input start, x0, y0, w, h, color, mode, pready,
                    output px, py, pcolor, pwrite, busy, done);
endinterface

// File: rtl/render_rect.sv
// render_rect: raster-scans a filled or outlined rectangle into a pixel write stream,
// skipping off-screen pixels and stalling on pready.
module render_rect #(
    parameter int NX = 10,
    parameter int NY = 9,
    parameter int CW = 9,
    parameter int XMAX = 640,
    parameter int YMAX = 480
) (
    input logic CLOCK_50,
    input logic resetn,
    render_rect_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
    state_t state, state_nx;
    logic [NX-1:0] xs, ws, xc;
    logic [NY-1:0] ys, hs, yc;
    logic [CW-1:0] col;
    logic md, last_x, last_y, on_edge, vis, adv;
    logic [NX:0] sx;
    logic [NY:0] sy;

    // Sums carry one extra bit so coordinates wrapping past 2^N count as off-screen.
    assign sx = {1'b0, xs} + {1'b0, xc};
    assign sy = {1'b0, ys} + {1'b0, yc};
    assign last_x = xc == ws - NX'(1);
    assign last_y = yc == hs - NY'(1);
    assign on_edge = xc == '0 || last_x || yc == '0 || last_y;
    assign vis = sx < (NX+1)'(XMAX) && sy < (NY+1)'(YMAX) && (!md || on_edge);
    assign adv = !bus.pwrite || bus.pready;
    assign bus.px = sx[NX-1:0];
    assign bus.py = sy[NY-1:0];
    assign bus.pcolor = col;

    always_comb begin
        bus.pwrite = state == DRAW && vis;
        bus.busy = state != IDLE;
        bus.done = state == DONE;
        state_nx = state == IDLE ? (bus.start ? ((bus.w == '0 || bus.h == '0) ? DONE : DRAW) : IDLE)
                 : state == DRAW ? ((adv && last_x && last_y) ? DONE : DRAW)
                 : IDLE;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state <= IDLE;
            xs <= '0;
            ys <= '0;
            ws <= '0;
            hs <= '0;
            col <= '0;
            md <= 1'b0;
            xc <= '0;
            yc <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && bus.start) begin
                xs <= bus.x0;
                ys <= bus.y0;
                ws <= bus.w;
                hs <= bus.h;
                col <= bus.color;
                md <= bus.mode;
                xc <= '0;
                yc <= '0;
            end else if (state == DRAW && adv) begin
                xc <= last_x ? '0 : xc + NX'(1);
                yc <= last_x ? yc + NY'(1) : yc;
            end
        end
    end
endmodule

// File: tb/tb_render_rect.sv
// tb_render_rect: randomized rectangles checked against a per-pixel list built from the drawing rules.
module tb_render_rect;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int n_tests = 0;
    int n_fail = 0;

    always #10 clk = ~clk;

    render_rect_if #(.NX(10), .NY(9), .CW(9)) bus ();
    render_rect dut (.CLOCK_50(clk), .resetn(resetn), .bus(bus.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // stall: 0 = pready always 1, 1 = random pready, 2 = hold off the second pixel for 3 cycles
    task automatic run_rect(input int x, input int y, input int ww, input int hh, input int c,
                            input int m, input int stall, input bit noisy);
        logic [27:0] q[$];
        int cyc, stalls, nw, sctr, total;
        bit seen;
        for (int j = 0; j < hh; j++)
            for (int i = 0; i < ww; i++)
                if (x + i < 640 && y + j < 480 &&
                    (m == 0 || i == 0 || i == ww - 1 || j == 0 || j == hh - 1))
                    q.push_back({10'(x + i), 9'(y + j), 9'(c)});
        total = q.size();
        bus.x0 = 10'(x);
        bus.y0 = 9'(y);
        bus.w = 10'(ww);
        bus.h = 9'(hh);
        bus.color = 9'(c);
        bus.mode = 1'(m);
        bus.start = 1'b1;
        tick;
        if (!noisy) bus.start = 1'b0;
        cyc = 1;
        stalls = 0;
        nw = 0;
        sctr = 0;
        seen = 1'b0;
        while (cyc < 4000) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            check("busy_draw", 32'(bus.busy), 32'd1);
            if (noisy) begin
                bus.x0 = 10'($urandom);
                bus.y0 = 9'($urandom);
                bus.w = 10'($urandom);
                bus.h = 9'($urandom);
                bus.color = 9'($urandom);
                bus.mode = 1'($urandom);
            end
            if (bus.pwrite) begin
                if (q.size() == 0) check("extra_write", 32'(bus.pwrite), 32'd0);
                else check("pixel", 32'({bus.px, bus.py, bus.pcolor}), 32'(q[0]));
                bus.pready = stall == 0 ? 1'b1 : stall == 1 ? 1'($urandom) : !(nw == 1 && sctr < 3);
                if (bus.pready) begin
                    if (q.size() != 0) void'(q.pop_front());
                    nw++;
                end else begin
                    stalls++;
                    sctr++;
                end
            end else begin
                bus.pready = 1'($urandom);
            end
            tick;
            cyc++;
        end
        check("done_seen", 32'(seen), 32'd1);
        check("done_cycle", cyc, ww * hh + stalls + 1);
        check("write_count", nw, total);
        check("busy_in_done", 32'(bus.busy), 32'd1);
        check("pwrite_in_done", 32'(bus.pwrite), 32'd0);
        tick;
        bus.start = 1'b0;
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_done", 32'(bus.done), 32'd0);
        tick;
        check("stay_idle", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.x0 = '0;
        bus.y0 = '0;
        bus.w = '0;
        bus.h = '0;
        bus.color = '0;
        bus.mode = 1'b0;
        bus.pready = 1'b1;
        tick;
        tick;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_pwrite", 32'(bus.pwrite), 32'd0);
        check("rst_px", 32'(bus.px), 32'd0);
        check("rst_py", 32'(bus.py), 32'd0);
        check("rst_pcolor", 32'(bus.pcolor), 32'd0);
        resetn = 1'b1;
        tick;
        run_rect(10, 5, 3, 2, 9'h1c7, 0, 0, 1'b0);
        run_rect(0, 0, 4, 3, 9'h038, 1, 0, 1'b0);
        run_rect(638, 478, 4, 4, 9'h007, 0, 0, 1'b0);
        run_rect(100, 100, 3, 2, 9'h155, 0, 2, 1'b0);
        run_rect(5, 5, 0, 3, 9'h0aa, 0, 0, 1'b0);
        run_rect(5, 5, 3, 0, 9'h0aa, 1, 0, 1'b1);
        run_rect(20, 30, 5, 4, 9'h1ff, 1, 1, 1'b1);
        // Reset in the middle of a large fill must stop writes immediately.
        bus.x0 = 10'd50;
        bus.y0 = 9'd50;
        bus.w = 10'd20;
        bus.h = 9'd20;
        bus.mode = 1'b0;
        bus.pready = 1'b1;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        repeat (4) tick;
        check("mid_draw_pwrite", 32'(bus.pwrite), 32'd1);
        check("mid_draw_px", 32'(bus.px), 32'd54);
        resetn = 1'b0;
        tick;
        resetn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("post_rst_pwrite", 32'(bus.pwrite), 32'd0);
            check("post_rst_busy", 32'(bus.busy), 32'd0);
            check("post_rst_done", 32'(bus.done), 32'd0);
            tick;
        end
        for (int r = 0; r < 40; r++) begin
            int x, y;
            x = ($urandom % 4 == 0) ? int'($urandom_range(600, 1023)) : int'($urandom_range(0, 700));
            y = ($urandom % 4 == 0) ? int'($urandom_range(450, 511)) : int'($urandom_range(0, 500));
            run_rect(x, y, int'($urandom_range(0, 9)), int'($urandom_range(0, 9)), int'($urandom_range(0, 511)),
                     int'($urandom % 2), int'($urandom % 3), 1'($urandom));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
